sram_write_datapath: RTL and testbench
======================================

// Module: sram_write_datapath
// PURPOSE
// Downstream datapath for the SRAM write-cycle FSM. Consumes its latch/count/DE/nWE/writing strobes and
// drives the SRAM pins: address counter, write-data register, data-bus enable, registered nWE and nCE.
// Tracks the number of committed words. Flags writes past the top address and illegal address reloads.
// PARAMETERS
// ADDR_W     8               SRAM address width
// DATA_W     8               SRAM data width
// LAST_ADDR  (1<<ADDR_W)-1   highest writable address; a commit at this address sets full
// PORTS
// clk          in   1          system clock, all logic on rising edge
// reset        in   1          synchronous, active-high
// latch        in   1          from write FSM: capture din this cycle
// count        in   1          from write FSM: 0->1 edge marks end of one write
// DE           in   1          from write FSM: start driving data bus
// nWE          in   1          from write FSM: active-low write strobe request
// writing      in   1          from write FSM: write burst in progress
// din          in   DATA_W     host write data
// addr_load    in   1          load addr_init into address counter
// addr_init    in   ADDR_W     start address for next burst
// sram_addr    out  ADDR_W     SRAM address
// sram_dq_out  out  DATA_W     data driven onto SRAM bus (valid while sram_dq_oe=1)
// sram_dq_oe   out  1          tristate enable for sram_dq_out
// sram_nwe     out  1          SRAM write enable, active low
// sram_nce     out  1          SRAM chip enable, active low
// full         out  1          last address written; further writes blocked
// words_written out ADDR_W+1   committed write count since last accepted load/reset
// wr_err       out  1          sticky error flag
// BEHAVIOUR
// - Reset (reset=1 on a rising edge): sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_nwe=1, sram_nce=1,
//   full=0, words_written=0, wr_err=0, internal count_q=1. Reset overrides every other input,
//   including mid-burst: bus released and nWE deasserted on the next edge.
// - All outputs registered; every strobe-to-pin path has exactly 1 cycle latency.
// - Data: latch=1 -> sram_dq_out<=din next edge; held otherwise.
// - sram_nwe <= nWE | full (write strobe suppressed while full).
// - sram_dq_oe <= DE | ~nWE | ~sram_nwe: asserts with DE, covers the whole sram_nwe low window and
//   one extra cycle after sram_nwe returns high (data hold).
// - sram_nce <= ~writing.
// - Commit event = count & ~count_q (count_q is count delayed one cycle).
//   On commit with full=0: words_written += 1; if sram_addr==LAST_ADDR then full<=1 and sram_addr holds,
//   else sram_addr <= sram_addr+1. No wrap-around ever.
//   On commit with full=1: sram_addr, words_written unchanged; wr_err<=1.
// - addr_load with writing=0: sram_addr<=addr_init, full<=0, words_written<=0, wr_err<=0.
//   addr_load with writing=1: ignored, wr_err<=1. Commit and rejected load on the same edge: commit
//   processed normally, error set.
//   addr_load with writing=0 and a commit on the same edge (FSM back to IDLE): load wins.
// - words_written saturates at 1<<ADDR_W (cannot exceed since full blocks further commits).
// - No internal FSM beyond edge-detect register; burst sequencing belongs to the write FSM.
// TESTING
// 1 Reset: hold reset 2 cycles -> addr=0, nwe=1, nce=1, oe=0, full=0, words=0, err=0.
// 2 Load 0x10, din=0xA5, one write cycle -> dq_out=0xA5, nwe low 1 cycle inside oe window, oe drops
//   1 cycle after nwe rises, then addr=0x11, words=1.
// 3 Burst of 3 writes (din 0x01,0x02,0x03) from 0x20 -> data at 0x20..0x22, final addr 0x23, words=3,
//   nce low across burst.
// 4 Load LAST_ADDR (0xFF), 2 writes -> first commits, full=1, addr stays 0xFF; second: nwe stays 1,
//   words=1, err=1; load 0x00 while idle clears full and err.
// 5 addr_load=1 with writing=1 -> addr unchanged, err=1, burst continues correctly.
// 6 Reset asserted while nwe=0 -> next edge nwe=1, oe=0, addr=0, words=0.

Source files
------------

// File: rtl/sram_write_datapath.sv
// SRAM write datapath: address counter, data register, bus enable,
// registered nWE/nCE, committed-word count, full and sticky error.
//
// Ports:
//   clk, reset          rising-edge clock, sync active-high reset
//   latch,count,DE,nWE  strobes from the write FSM
//   writing             burst-in-progress from the write FSM
//   din                 host write data
//   addr_load,addr_init start-address load (ignored mid-burst)
//   sram_addr           SRAM address
//   sram_dq_out/_oe     data to SRAM bus and its tristate enable
//   sram_nwe, sram_nce  active-low write and chip enables
//   full                top address committed, further writes blocked
//   words_written       committed words since last load/reset
//   wr_err              sticky error (write while full, bad reload)
module sram_write_datapath #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int unsigned LAST_ADDR = (1 << ADDR_W) - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              latch,
  input  logic              count,
  input  logic              DE,
  input  logic              nWE,
  input  logic              writing,
  input  logic [DATA_W-1:0] din,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_init,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  output logic              sram_nwe,
  output logic              sram_nce,
  output logic              full,
  output logic [ADDR_W:0]   words_written,
  output logic              wr_err
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);
  localparam logic [ADDR_W:0]   WMAX = (ADDR_W+1)'(1) << ADDR_W;

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_dq;
  logic              r_oe;
  logic              r_nwe;
  logic              r_nce;
  logic              r_full;
  logic [ADDR_W:0]   r_words;
  logic              r_err;
  logic              r_count_q;

  logic w_commit;
  logic w_load_ok;
  logic w_load_bad;

  // One commit per rising edge of count.
  assign w_commit   = count & ~r_count_q;
  assign w_load_ok  = addr_load & ~writing;
  assign w_load_bad = addr_load & writing;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr    <= '0;
      r_dq      <= '0;
      r_oe      <= 1'b0;
      r_nwe     <= 1'b1;
      r_nce     <= 1'b1;
      r_full    <= 1'b0;
      r_words   <= '0;
      r_err     <= 1'b0;
      r_count_q <= 1'b1;
    end else begin
      r_count_q <= count;
      if (latch)
        r_dq <= din;
      r_nwe <= nWE | r_full;
      // Bus stays driven one cycle past the nWE rise for data hold.
      r_oe  <= DE | ~nWE | ~r_nwe;
      r_nce <= ~writing;

      // An idle load restarts the burst and beats a same-edge commit.
      if (w_load_ok) begin
        r_addr  <= addr_init;
        r_full  <= 1'b0;
        r_words <= '0;
        r_err   <= 1'b0;
      end else begin
        if (w_load_bad)
          r_err <= 1'b1;
        if (w_commit) begin
          if (r_full) begin
            r_err <= 1'b1;
          end else begin
            if (r_words != WMAX)
              r_words <= r_words + 1'b1;
            if (r_addr == LAST)
              r_full <= 1'b1;
            else
              r_addr <= r_addr + 1'b1;
          end
        end
      end
    end
  end

  assign sram_addr     = r_addr;
  assign sram_dq_out   = r_dq;
  assign sram_dq_oe    = r_oe;
  assign sram_nwe      = r_nwe;
  assign sram_nce      = r_nce;
  assign full          = r_full;
  assign words_written = r_words;
  assign wr_err        = r_err;

endmodule

// File: tb/tb_sram_write_datapath.sv
// Scoreboard bench for sram_write_datapath: randomized write bursts
// against a reference model plus an SRAM image comparison.
module tb_sram_write_datapath;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       latch = 1'b0;
  logic       count = 1'b0;
  logic       DE = 1'b0;
  logic       nWE = 1'b1;
  logic       writing = 1'b0;
  logic [7:0] din = '0;
  logic       addr_load = 1'b0;
  logic [7:0] addr_init = '0;
  logic [7:0] sram_addr;
  logic [7:0] sram_dq_out;
  logic       sram_dq_oe;
  logic       sram_nwe;
  logic       sram_nce;
  logic       full;
  logic [8:0] words_written;
  logic       wr_err;

  sram_write_datapath #(
    .ADDR_W(8),
    .DATA_W(8),
    .LAST_ADDR(255)
  ) dut (
    .clk(clk),
    .reset(reset),
    .latch(latch),
    .count(count),
    .DE(DE),
    .nWE(nWE),
    .writing(writing),
    .din(din),
    .addr_load(addr_load),
    .addr_init(addr_init),
    .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe),
    .sram_nwe(sram_nwe),
    .sram_nce(sram_nce),
    .full(full),
    .words_written(words_written),
    .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int dq;
    int oe;
    int nwe;
    int nce;
    int full;
    int words;
    int err;
  } exp_t;

  exp_t q[$];
  int   exp_mem[int];
  int   act_mem[int];
  int   n_tests = 0;
  int   n_fail = 0;

  // Reference state: what the pins should show after each edge.
  int m_addr, m_dq, m_words;
  bit m_oe, m_nwe, m_nce, m_full, m_err, m_cq;
  // Previous edge's write-strobe request, for the bus hold window.
  bit m_prev_req;

  task automatic cmp(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and predict the result of the next edge.
  task automatic step(input bit rst, input bit lt, input bit cn,
                      input bit de, input bit we, input bit wr,
                      input int d, input bit ld, input int init);
    exp_t e;
    bit   rise;
    bit   blocked;
    @(negedge clk);
    reset     = rst;
    latch     = lt;
    count     = cn;
    DE        = de;
    nWE       = we;
    writing   = wr;
    din       = 8'(d);
    addr_load = ld;
    addr_init = 8'(init);
    if (rst) begin
      m_addr = 0; m_dq = 0; m_words = 0;
      m_oe = 0; m_nwe = 1; m_nce = 1;
      m_full = 0; m_err = 0; m_cq = 1;
      m_prev_req = 0;
    end else begin
      rise    = cn && !m_cq;
      blocked = m_full;
      m_cq    = cn;
      m_oe    = de || !we || m_prev_req;
      m_prev_req = !m_nwe ? 1'b0 : 1'b0;
      m_nwe   = we || blocked;
      m_prev_req = !m_nwe;
      m_nce   = !wr;
      if (lt) m_dq = d & 255;
      if (ld && !wr) begin
        m_addr = init & 255;
        m_full = 0; m_words = 0; m_err = 0;
      end else begin
        if (ld) m_err = 1;
        if (rise && blocked) m_err = 1;
        if (rise && !blocked) begin
          m_words = (m_words < 256) ? m_words + 1 : 256;
          if (m_addr == 255) m_full = 1;
          else m_addr = m_addr + 1;
        end
      end
    end
    e.addr = m_addr; e.dq = m_dq; e.oe = m_oe;
    e.nwe = m_nwe; e.nce = m_nce; e.full = m_full;
    e.words = m_words; e.err = m_err;
    q.push_back(e);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic load(input int a);
    step(0, 0, 0, 0, 1, 0, 0, 1, a);
  endtask

  // One FSM write cycle: latch, strobe, count edge, recover.
  task automatic write_word(input int d, input bit rej);
    if (!m_full) exp_mem[m_addr] = d;
    step(0, 1, 0, 1, 1, 1, d, 0, 0);
    step(0, 0, 0, 1, 0, 1, 0, rej, rej ? $urandom_range(0, 255) : 0);
    step(0, 0, 1, 0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0, 0, 0);
  endtask

  // Monitor: pops one expectation per edge and checks every pin.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp("addr", int'(sram_addr), e.addr);
        cmp("dq_out", int'(sram_dq_out), e.dq);
        cmp("dq_oe", int'(sram_dq_oe), e.oe);
        cmp("nwe", int'(sram_nwe), e.nwe);
        cmp("nce", int'(sram_nce), e.nce);
        cmp("full", int'(full), e.full);
        cmp("words", int'(words_written), e.words);
        cmp("err", int'(wr_err), e.err);
        if (sram_nwe === 1'b0) begin
          cmp("oe_during_nwe", int'(sram_dq_oe), 1);
          act_mem[int'(sram_addr)] = int'(sram_dq_out);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int a;
    int nb;
    step(1, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0, 0, 0);
    idle();
    cmp("rst_addr", int'(sram_addr), 0);
    cmp("rst_nwe", int'(sram_nwe), 1);
    cmp("rst_nce", int'(sram_nce), 1);
    cmp("rst_oe", int'(sram_dq_oe), 0);
    cmp("rst_full", int'(full), 0);
    cmp("rst_words", int'(words_written), 0);
    cmp("rst_err", int'(wr_err), 0);

    load(8'h10);
    write_word(8'hA5, 0);
    idle();
    cmp("t2_dq", int'(sram_dq_out), 8'hA5);
    cmp("t2_addr", int'(sram_addr), 8'h11);
    cmp("t2_words", int'(words_written), 1);
    cmp("t2_oe_off", int'(sram_dq_oe), 0);

    load(8'h20);
    write_word(8'h01, 0);
    write_word(8'h02, 0);
    write_word(8'h03, 0);
    cmp("t3_nce_burst", int'(sram_nce), 0);
    idle();
    cmp("t3_addr", int'(sram_addr), 8'h23);
    cmp("t3_words", int'(words_written), 3);

    load(8'hFF);
    write_word(8'h5A, 0);
    write_word(8'h66, 0);
    idle();
    cmp("t4_full", int'(full), 1);
    cmp("t4_addr", int'(sram_addr), 8'hFF);
    cmp("t4_words", int'(words_written), 1);
    cmp("t4_err", int'(wr_err), 1);
    load(8'h00);
    idle();
    cmp("t4_clr_full", int'(full), 0);
    cmp("t4_clr_err", int'(wr_err), 0);

    load(8'h40);
    write_word(8'h77, 1);
    write_word(8'h78, 0);
    idle();
    cmp("t5_addr", int'(sram_addr), 8'h42);
    cmp("t5_err", int'(wr_err), 1);

    load(8'h30);
    exp_mem[8'h30] = 8'hC3;
    step(0, 1, 0, 1, 1, 1, 8'hC3, 0, 0);
    step(0, 0, 0, 1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 1, 0, 1, 0, 0, 0);
    cmp("t6_nwe_low", int'(sram_nwe), 0);
    idle();
    cmp("t6_nwe", int'(sram_nwe), 1);
    cmp("t6_oe", int'(sram_dq_oe), 0);
    cmp("t6_addr", int'(sram_addr), 0);
    cmp("t6_words", int'(words_written), 0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        step(1, 0, 0, 0, 1, 0, 0, 0, 0);
      end else if ($urandom_range(0, 2) == 0) begin
        a = $urandom_range(248, 255);
        load(a);
      end else if ($urandom_range(0, 1) == 0) begin
        a = $urandom_range(0, 255);
        load(a);
      end
      nb = $urandom_range(1, 5);
      for (int j = 0; j < nb; j++)
        write_word($urandom_range(0, 255),
                   $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0)
        load($urandom_range(0, 255));
      idle();
    end

    idle();
    idle();
    @(posedge clk);
    #2;
    cmp("queue_drained", q.size(), 0);
    cmp("mem_entries", act_mem.num(), exp_mem.num());
    foreach (exp_mem[k])
      cmp($sformatf("mem[%0h]", k),
          act_mem.exists(k) ? act_mem[k] : -1, exp_mem[k]);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
